// File: rtl/libstf_pkg.sv
// Shared types and helpers for the stream packing blocks.
package libstf_pkg;

    localparam int KEEP_MAX  = 64;
    localparam int PKT_ELEMS = 4;

    // Holds acc_cnt + k for the default beat width (0..2N-1).
    typedef logic [$clog2(2*PKT_ELEMS)-1:0] count_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
        logic [KEEP_MAX-1:0] m;
        if (n >= KEEP_MAX)
            m = '1;
        else
            m = ({{(KEEP_MAX-1){1'b0}}, 1'b1} << n) - {{(KEEP_MAX-1){1'b0}}, 1'b1};
        return m;
    endfunction

endpackage

// File: rtl/stream_packer_rotator.sv
// Places N input elements into a 2N-element window, starting at slot 'shift'.
module elem_rotator #(
    parameter int ELEM_WIDTH   = 8,
    parameter int NUM_ELEMENTS = 4
) (
    input  logic [NUM_ELEMENTS*ELEM_WIDTH-1:0]   in_elems,
    input  logic [$clog2(NUM_ELEMENTS)-1:0]      shift,
    output logic [2*NUM_ELEMENTS*ELEM_WIDTH-1:0] window
);

    localparam int BW = NUM_ELEMENTS * ELEM_WIDTH;

    always_comb begin
        window = {{BW{1'b0}}, in_elems} << (int'(shift) * ELEM_WIDTH);
    end

endmodule

// File: rtl/stream_packer.sv
// Packs partially filled beats into dense beats and reports per-packet element counts.
module stream_packer
    import libstf_pkg::*;
#(
    parameter int ELEM_WIDTH   = 8,
    parameter int NUM_ELEMENTS = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_ELEMENTS*ELEM_WIDTH-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]          in_keep,
    input  logic                             in_last,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [NUM_ELEMENTS*ELEM_WIDTH-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]          out_keep,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CNT_WIDTH-1:0]             out_pkt_elems,
    output logic                             keep_err
);

    localparam int N  = NUM_ELEMENTS;
    localparam int EW = ELEM_WIDTH;
    localparam int BW = N * EW;
    localparam int CW = $clog2(2 * N);
    localparam int SW = $clog2(N);
    localparam logic [CW-1:0] N_C = CW'(N);

    state_t               state, state_n;
    logic [CW-1:0]        acc_cnt, acc_cnt_n;
    logic [BW-1:0]        acc, acc_n;
    logic [CNT_WIDTH-1:0] pkt_cnt, pkt_cnt_n;

    logic                 out_valid_n, out_last_n, keep_err_n;
    logic [N-1:0]         out_keep_n;
    logic [BW-1:0]        out_data_n;
    logic [CNT_WIDTH-1:0] out_pkt_elems_n;

    logic                 out_ld, accept;
    logic [CW-1:0]        k, s;
    logic [N-1:0]         mask_k, mask_s, mask_acc;
    logic [BW-1:0]        in_masked, acc_masked;
    logic [2*BW-1:0]      rot, win;
    logic [CNT_WIDTH-1:0] pkt_tot;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CW-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(CNT_WIDTH+1-CW){1'b0}}, b};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // Zero every slot beyond the live count so the window and unused output slots are deterministic.
    always_comb begin
        k        = CW'($countones(in_keep));
        s        = acc_cnt + k;
        mask_k   = N'(keep_mask(k));
        mask_s   = N'(keep_mask(s));
        mask_acc = N'(keep_mask(acc_cnt));
        for (int i = 0; i < N; i++) begin
            in_masked[i*EW +: EW]  = (CW'(i) < k)       ? in_data[i*EW +: EW] : '0;
            acc_masked[i*EW +: EW] = (CW'(i) < acc_cnt) ? acc[i*EW +: EW]     : '0;
        end
    end

    elem_rotator #(
        .ELEM_WIDTH   (EW),
        .NUM_ELEMENTS (N)
    ) u_rot (
        .in_elems (in_masked),
        .shift    (acc_cnt[SW-1:0]),
        .window   (rot)
    );

    assign win = rot | {{BW{1'b0}}, acc_masked};

    always_comb begin
        out_ld   = !out_valid || out_ready;
        in_ready = out_ld && (state == RUN);
        accept   = in_valid && in_ready;
        pkt_tot  = sat_add(pkt_cnt, k);

        state_n         = state;
        acc_n           = acc;
        acc_cnt_n       = acc_cnt;
        pkt_cnt_n       = pkt_cnt;
        out_valid_n     = out_valid;
        out_data_n      = out_data;
        out_keep_n      = out_keep;
        out_last_n      = out_last;
        out_pkt_elems_n = out_pkt_elems;
        keep_err_n      = keep_err;

        if (accept && (in_keep != mask_k))
            keep_err_n = 1'b1;

        if (out_ld) begin
            out_valid_n = 1'b0;
            if (state == FLUSH) begin
                out_valid_n     = 1'b1;
                out_data_n      = acc_masked;
                out_keep_n      = mask_acc;
                out_last_n      = 1'b1;
                out_pkt_elems_n = pkt_cnt;
                pkt_cnt_n       = '0;
                acc_cnt_n       = '0;
                state_n         = RUN;
            end else if (accept) begin
                if (s >= N_C) begin
                    out_valid_n = 1'b1;
                    out_data_n  = win[BW-1:0];
                    out_keep_n  = '1;
                    out_last_n  = 1'b0;
                    acc_n       = win[2*BW-1:BW];
                    acc_cnt_n   = s - N_C;
                    pkt_cnt_n   = pkt_tot;
                    if (in_last) begin
                        if (s == N_C) begin
                            out_last_n      = 1'b1;
                            out_pkt_elems_n = pkt_tot;
                            pkt_cnt_n       = '0;
                        end else begin
                            // Remainder does not fit: spend one extra cycle emitting it.
                            state_n = FLUSH;
                        end
                    end
                end else if (in_last) begin
                    out_valid_n     = 1'b1;
                    out_data_n      = win[BW-1:0];
                    out_keep_n      = mask_s;
                    out_last_n      = 1'b1;
                    out_pkt_elems_n = pkt_tot;
                    pkt_cnt_n       = '0;
                    acc_cnt_n       = '0;
                end else begin
                    acc_n     = win[BW-1:0];
                    acc_cnt_n = s;
                    pkt_cnt_n = pkt_tot;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            acc_cnt       <= '0;
            pkt_cnt       <= '0;
            out_valid     <= 1'b0;
            out_keep      <= '0;
            out_last      <= 1'b0;
            out_pkt_elems <= '0;
            keep_err      <= 1'b0;
        end else begin
            state         <= state_n;
            acc_cnt       <= acc_cnt_n;
            pkt_cnt       <= pkt_cnt_n;
            out_valid     <= out_valid_n;
            out_keep      <= out_keep_n;
            out_last      <= out_last_n;
            out_pkt_elems <= out_pkt_elems_n;
            keep_err      <= keep_err_n;
        end
    end

    always_ff @(posedge clk) begin
        acc      <= acc_n;
        out_data <= out_data_n;
    end

endmodule

// File: tb/tb_stream_packer.sv
// Directed and randomized checks of stream_packer against an element-queue reference model.
module tb_stream_packer;

    localparam int N  = 4;
    localparam int EW = 8;
    localparam int CN = 32;
    localparam int BW = N * EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic [N-1:0]  in_keep = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic [N-1:0]  out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CN-1:0] out_pkt_elems;
    logic          keep_err;

    always #5 clk = ~clk;

    stream_packer #(
        .ELEM_WIDTH   (EW),
        .NUM_ELEMENTS (N),
        .CNT_WIDTH    (CN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_keep       (in_keep),
        .in_last       (in_last),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pkt_elems (out_pkt_elems),
        .keep_err      (keep_err)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
        logic [CN-1:0] elems;
    } beat_t;

    beat_t         exp_q[$];
    logic [EW-1:0] pend[$];
    int            pkt_total = 0;
    logic          model_err = 1'b0;

    int tests = 0;
    int fails = 0;
    int rdy_prob = 100;
    int stall_left = 0;

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data;
    logic [N-1:0]  prev_keep;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] low_ones(input int n);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [BW-1:0] elem_mask(input logic [N-1:0] kp);
        logic [BW-1:0] m;
        for (int i = 0; i < N; i++) m[i*EW +: EW] = kp[i] ? '1 : '0;
        return m;
    endfunction

    // Take n elements off the pending queue as one expected output beat.
    task automatic emit_beat(input int n, input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) b.data[i*EW +: EW] = pend.pop_front();
        b.keep  = low_ones(n);
        b.last  = last;
        b.elems = CN'(pkt_total);
        exp_q.push_back(b);
    endtask

    task automatic model_accept(input logic [N-1:0] kp, input logic [BW-1:0] d, input logic last);
        int k;
        k = $countones(kp);
        if (kp != low_ones(k)) model_err = 1'b1;
        for (int i = 0; i < k; i++) pend.push_back(d[i*EW +: EW]);
        pkt_total += k;
        while (pend.size() > N || (!last && pend.size() == N)) emit_beat(N, 1'b0);
        if (last) begin
            emit_beat(pend.size(), 1'b1);
            pkt_total = 0;
        end
    endtask

    // One clock: drive out_ready, observe away from the edge, score, then advance to the next negedge.
    task automatic cycle(output logic accepted);
        beat_t e;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(0, 99) < rdy_prob);
        end
        #1;
        accepted = in_valid && in_ready;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_keep", out_keep, prev_keep);
            check("hold_last", out_last, prev_last);
        end
        if (out_valid && !out_ready) check("in_ready_backpressure", in_ready, 0);
        if (out_valid && out_ready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_keep", out_keep, e.keep);
                check("beat_last", out_last, e.last);
                check("beat_data", out_data & elem_mask(e.keep), e.data);
                if (e.last) check("beat_pkt_elems", out_pkt_elems, e.elems);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_keep  = out_keep;
        prev_last  = out_last;
        if (accepted) model_accept(in_keep, in_data, in_last);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] kp, input logic [BW-1:0] d, input logic last);
        logic acc;
        int   guard;
        guard    = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_keep  = kp;
        in_data  = d;
        in_last  = last;
        while (!acc && guard < 100) begin
            cycle(acc);
            guard++;
        end
        check("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        logic          acc;
        logic [N-1:0]  kp;
        int            len;
        int            guard;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_keep", out_keep, 0);
        check("reset_out_last", out_last, 0);
        check("reset_pkt_elems", out_pkt_elems, 0);
        check("reset_keep_err", keep_err, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Two half beats merge into one full last beat.
        send(4'b0011, 32'h0000_A1A0, 1'b0);
        send(4'b0011, 32'h0000_A3A2, 1'b1);
        check("t1_data", out_data, 32'hA3A2_A1A0);
        check("t1_last", out_last, 1);
        check("t1_elems", out_pkt_elems, 4);
        idle(2);

        // Overflow on the last beat forces a flush cycle.
        send(4'b0111, 32'h00A2_A1A0, 1'b0);
        send(4'b0111, 32'h00B2_B1B0, 1'b1);
        check("t2_first_data", out_data, 32'hB0A2_A1A0);
        check("t2_first_last", out_last, 0);
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_flush", in_ready, 0);
        idle(3);

        // Downstream stall mid-packet.
        send(4'b1111, 32'hC3C2_C1C0, 1'b0);
        stall_left = 5;
        send(4'b1111, 32'hC7C6_C5C4, 1'b0);
        send(4'b1111, 32'hCBCA_C9C8, 1'b1);
        idle(3);

        // Zero-length last beat on an empty accumulator.
        send(4'b0000, 32'hDEAD_BEEF, 1'b1);
        idle(2);

        // Non-contiguous keep is flagged but processed by count.
        send(4'b0101, 32'h00E2_00E0, 1'b0);
        send(4'b0011, 32'h0000_E5E4, 1'b1);
        idle(2);
        check("t5_keep_err", keep_err, 1);
        send(4'b0001, 32'h0000_00F0, 1'b1);
        idle(2);
        check("t5_keep_err_sticky", keep_err, 1);

        // Reset with three elements parked in the accumulator.
        send(4'b0111, 32'h0012_1110, 1'b0);
        idle(1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cycle(acc);
        rst_n = 1'b1;
        pend.delete();
        pkt_total  = 0;
        model_err  = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_keep_err", keep_err, 0);
        check("t6_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        send(4'b1111, 32'h3332_3130, 1'b1);
        check("t6_data", out_data, 32'h3332_3130);
        check("t6_keep", out_keep, 4'b1111);
        idle(2);

        // Randomized traffic with random backpressure.
        rdy_prob = 70;
        for (int i = 0; i < 400; i++) begin
            len = $urandom_range(0, N);
            kp  = low_ones(len);
            if ($urandom_range(0, 19) == 0) kp = N'($urandom());
            send(kp, $urandom(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        send(4'b0011, $urandom(), 1'b1);
        rdy_prob = 100;
        guard    = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && guard < 50) begin
            cycle(acc);
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_idle", out_valid, 0);
        check("random_keep_err", keep_err, model_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
